demux_2bit_router: RTL and testbench
====================================

# demux_2bit_router

Registered 1-to-2 demultiplexer with valid/ready handshaking; the inverse of the 2-bit selector datapath. Accepts one 2-bit word per cycle on a single input port. Steers it, by `signal`, into one of two independent 2-entry output queues. Each queue presents its head word on its own output port, so a stalled consumer on one channel never blocks traffic to the other channel.

## Interface
Parameters:
- `WIDTH`, 2, data word width in bits.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `In1`  in  WIDTH  input data word.
- `in_valid`  in  1  `In1`/`signal` hold a valid transfer.
- `signal`  in  1  route select: 0 → channel 1, 1 → channel 2.
- `in_ready`  out  1  the selected channel can accept this cycle.
- `out1`  out  WIDTH  channel 1 head word.
- `out1_valid`  out  1  channel 1 queue non-empty.
- `out1_ready`  in  1  channel 1 consumer takes head this cycle.
- `out2`  out  WIDTH  channel 2 head word.
- `out2_valid`  out  1  channel 2 queue non-empty.
- `out2_ready`  in  1  channel 2 consumer takes head this cycle.
- `cnt1`, `cnt2`  out  8  words delivered per channel (only with `DEMUX_COUNT_EN`).

## Operation
- Each channel queue has 3 states: EMPTY, ONE, TWO.
- Push into channel k when `in_valid && in_ready && signal == k-1`. Pop from channel k when `outk_valid && outk_ready`.
- Queue state transitions:
  - Push only: EMPTY→ONE, ONE→TWO.
  - Pop only: TWO→ONE, ONE→EMPTY.
  - Push and pop together in ONE: stays ONE; head becomes the pushed word.
  - Push and pop together in TWO: cannot occur, because `in_ready` is low when the selected queue is full.
- `in_ready` = selected queue not in TWO; it is combinational from `signal` and queue state only. There is no path from `out*_ready` to `in_ready`. A full queue frees a slot the cycle after a pop.
- Ordering: FIFO per channel. No reordering between words sent to the same channel; no ordering relation between channels.
- `outk` = head entry register; it is don't-care-free and holds its last value when EMPTY.
- `outk_valid` = queue state ≠ EMPTY, driven from registers.
- Input with `in_valid` low is ignored regardless of `signal`. `signal` is sampled only on an accepted transfer.
- Reset (asynchronous, any time including mid-transfer):
  - Both queues go to EMPTY. `out1`, `out2` = 0. `out1_valid`, `out2_valid` = 0. Counters = 0.
  - `in_ready` is forced to 0 while `reset` is high.
  - Words in flight are discarded.

## Timing
- Latency: a word accepted at edge N is visible on `outk` with `outk_valid=1` after edge N, i.e. one cycle.
- Throughput: one word per cycle into either channel. A channel drained every cycle never deasserts `in_ready`.
- After a pop of a TWO queue at edge N, `in_ready` for that channel rises after edge N.
- Reset release: the first push may occur at the first rising edge after `reset` falls.

## Configuration
- `DEMUX_COUNT_EN` defined:
  - `cnt1` and `cnt2` exist. Each increments by 1 on every pop of its channel.
  - Counters wrap 255→0 and reset to 0.
- `DEMUX_COUNT_EN` undefined: the ports and counter logic are absent. All other behaviour is identical.

## Structure
- Shared package `demux_pkg`:
  - default `WIDTH` constant (2).
  - queue state encoding typedef: EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
- Sub-module `demux_chan_fifo`: 2-entry queue with push/pop/full/valid/head and optional counter. It is instantiated twice; the top contains only steering and `in_ready` selection.

## Test plan
- Reset then single push: `In1=2'b10`, `signal=0`, `in_valid=1` for one cycle → next cycle `out1=2'b10`, `out1_valid=1`, `out2_valid=0`.
- Fill channel 2:
  - With `out2_ready=0`, push 2'b01 then 2'b11 with `signal=1`.
  - Required response: `in_ready` low while `signal=1`, high while `signal=0`.
  - Raise `out2_ready` → pops 2'b01 then 2'b11 in order.
- Independence: hold channel 2 full, stream 2'b00..2'b11 to channel 1 with `out1_ready=1` → one word per cycle appears on `out1`, delayed one cycle.
- Simultaneous push/pop in ONE: channel 1 holds 2'b01, push 2'b10 with `out1_ready=1` → `out1=2'b10`, `out1_valid` stays 1, queue stays ONE.
- Mid-operation reset: both queues TWO; assert `reset` asynchronously between edges → all valids and outputs 0 immediately, `in_ready=0`; after release, push succeeds on the first edge.
- `DEMUX_COUNT_EN`: deliver 257 words on channel 1 → `cnt1=1`, `cnt2=0`.

Source files
------------

// File: rtl/demux_2bit_router_pkg.sv
// ----------------------------------------------------------------------------
// demux_pkg
// Shared definitions for the 2-bit demultiplexing router.
//   DEFAULT_WIDTH : default data word width (2 bits).
//   qstate_e      : occupancy state of one 2-entry channel queue.
// The optional per-channel delivery counters are controlled by the
// DEMUX_COUNT_EN macro in the files that use this package.
// ----------------------------------------------------------------------------
package demux_pkg;

  localparam int DEFAULT_WIDTH = 2;

  typedef enum logic [1:0] {
    Q_EMPTY = 2'd0,
    Q_ONE   = 2'd1,
    Q_TWO   = 2'd2
  } qstate_e;

endpackage

// File: rtl/demux_2bit_router_if.sv
// ----------------------------------------------------------------------------
// demux_2bit_router_if
// Bus bundle of the router: one input stream and two output streams.
//   In1/in_valid/signal/in_ready : input word, valid, route select, ready
//   out1/out1_valid/out1_ready   : channel 1 head word and handshake
//   out2/out2_valid/out2_ready   : channel 2 head word and handshake
//   cnt1/cnt2                    : per-channel delivered-word counters,
//                                  present only when DEMUX_COUNT_EN is defined
// Modports: master = producer/consumer side, slave = router side.
// ----------------------------------------------------------------------------
interface demux_2bit_router_if #(
  parameter int WIDTH = demux_pkg::DEFAULT_WIDTH
);

  logic [WIDTH-1:0] In1;
  logic             in_valid;
  logic             signal;
  logic             in_ready;
  logic [WIDTH-1:0] out1;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out2;
  logic             out2_valid;
  logic             out2_ready;
`ifdef DEMUX_COUNT_EN
  logic [7:0]       cnt1;
  logic [7:0]       cnt2;
`endif

  modport master (
    output In1, in_valid, signal, out1_ready, out2_ready,
    input  in_ready, out1, out1_valid, out2, out2_valid
`ifdef DEMUX_COUNT_EN
    , input cnt1, cnt2
`endif
  );

  modport slave (
    input  In1, in_valid, signal, out1_ready, out2_ready,
    output in_ready, out1, out1_valid, out2, out2_valid
`ifdef DEMUX_COUNT_EN
    , output cnt1, cnt2
`endif
  );

endinterface

// File: rtl/demux_2bit_router_chan_fifo.sv
// ----------------------------------------------------------------------------
// demux_chan_fifo
// Two-entry queue for one output channel of the router.
//   clk, rst : clock, asynchronous active-high reset
//   push_i   : write data_i this cycle (caller guarantees queue not full)
//   data_i   : word to enqueue
//   ready_i  : consumer takes the head this cycle
//   data_o   : head word (holds its last value when empty, 0 after reset)
//   valid_o  : queue non-empty
//   full_o   : queue holds two words
//   cnt_o    : words popped, wraps at 255 (only when DEMUX_COUNT_EN defined)
// ----------------------------------------------------------------------------
module demux_chan_fifo
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             valid_o,
  output logic             full_o
`ifdef DEMUX_COUNT_EN
  , output logic [7:0]     cnt_o
`endif
);

  qstate_e          state_q, state_d;
  logic [WIDTH-1:0] head_q, head_d;
  logic [WIDTH-1:0] tail_q, tail_d;
  logic             pop;

  assign valid_o = (state_q != Q_EMPTY);
  assign full_o  = (state_q == Q_TWO);
  assign data_o  = head_q;
  assign pop     = valid_o && ready_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= Q_EMPTY;
      head_q  <= '0;
      tail_q  <= '0;
    end else begin
      state_q <= state_d;
      head_q  <= head_d;
      tail_q  <= tail_d;
    end
  end

  always_comb begin
    state_d = state_q;
    head_d  = head_q;
    tail_d  = tail_q;
    case (state_q)
      Q_EMPTY: begin
        if (push_i) begin
          head_d  = data_i;
          state_d = Q_ONE;
        end
      end
      Q_ONE: begin
        case ({push_i, pop})
          2'b10: begin
            tail_d  = data_i;
            state_d = Q_TWO;
          end
          2'b01: state_d = Q_EMPTY;      // head keeps the departed word
          2'b11: head_d  = data_i;       // replace head, occupancy unchanged
          default: ;
        endcase
      end
      Q_TWO: begin
        // No push can arrive here: in_ready is low for a full queue.
        if (pop) begin
          head_d  = tail_q;
          state_d = Q_ONE;
        end
      end
      default: state_d = Q_EMPTY;
    endcase
  end

`ifdef DEMUX_COUNT_EN
  logic [7:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 8'd0;
    end else if (pop) begin
      cnt_q <= cnt_q + 8'd1;
    end
  end

  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/demux_2bit_router.sv
// ----------------------------------------------------------------------------
// demux_2bit_router
// Registered 1-to-2 demultiplexer. Each accepted input word is steered by
// `signal` into one of two independent 2-entry channel queues, so a stalled
// consumer on one channel never blocks the other.
//   clk   : clock
//   reset : asynchronous active-high reset (forces in_ready low while high)
//   bus   : demux_2bit_router_if slave modport (input stream, two outputs,
//           and cnt1/cnt2 when DEMUX_COUNT_EN is defined)
// ----------------------------------------------------------------------------
module demux_2bit_router
  import demux_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                 clk,
  input  logic                 reset,
  demux_2bit_router_if.slave   bus
);

  logic [1:0]       push;
  logic [1:0]       full;
  logic [1:0]       valid;
  logic [1:0]       rdy;
  logic [WIDTH-1:0] dout [2];
`ifdef DEMUX_COUNT_EN
  logic [7:0]       cnt [2];
`endif

  assign rdy = {bus.out2_ready, bus.out1_ready};

  // Depends only on reset, the route select and queue occupancy; the output
  // ready lines never reach in_ready.
  assign bus.in_ready = !reset && !full[bus.signal];

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    assign push[gi] = bus.in_valid && bus.in_ready && (bus.signal == 1'(gi));

    demux_chan_fifo #(
      .WIDTH(WIDTH)
    ) u_fifo (
      .clk     (clk),
      .rst     (reset),
      .push_i  (push[gi]),
      .data_i  (bus.In1),
      .ready_i (rdy[gi]),
      .data_o  (dout[gi]),
      .valid_o (valid[gi]),
      .full_o  (full[gi])
`ifdef DEMUX_COUNT_EN
      , .cnt_o (cnt[gi])
`endif
    );
  end

  assign bus.out1       = dout[0];
  assign bus.out2       = dout[1];
  assign bus.out1_valid = valid[0];
  assign bus.out2_valid = valid[1];
`ifdef DEMUX_COUNT_EN
  assign bus.cnt1 = cnt[0];
  assign bus.cnt2 = cnt[1];
`endif

endmodule

// File: tb/tb_demux_2bit_router.sv
// ----------------------------------------------------------------------------
// tb_demux_2bit_router
// Bench for demux_2bit_router. A queue-based model tracks what each channel
// must hold; a compare process checks all outputs against it on every
// falling edge, and directed steps add literal expectations.
// Counter checks are included when DEMUX_COUNT_EN is defined.
// ----------------------------------------------------------------------------
module tb_demux_2bit_router;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  demux_2bit_router_if #(.WIDTH(2)) bus ();

  demux_2bit_router #(.WIDTH(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Model: contents of each channel queue, last head seen, pops delivered.
  logic [1:0] q0[$];
  logic [1:0] q1[$];
  logic [1:0] last0 = 2'b00;
  logic [1:0] last1 = 2'b00;
  int         pops0 = 0;
  int         pops1 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic s, input logic [1:0] d,
                       input logic r1, input logic r2);
    bus.in_valid   = v;
    bus.signal     = s;
    bus.In1        = d;
    bus.out1_ready = r1;
    bus.out2_ready = r2;
  endtask

  // Behavioural model update on each active edge or asynchronous reset.
  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        q0.delete();
        q1.delete();
        last0 = 2'b00;
        last1 = 2'b00;
        pops0 = 0;
        pops1 = 0;
      end else begin
        bit acc, p0, p1;
        acc = bus.in_valid && ((bus.signal ? q1.size() : q0.size()) < 2);
        p0  = (q0.size() > 0) && bus.out1_ready;
        p1  = (q1.size() > 0) && bus.out2_ready;
        if (p0) begin void'(q0.pop_front()); pops0++; end
        if (p1) begin void'(q1.pop_front()); pops1++; end
        if (acc) begin
          if (bus.signal) q1.push_back(bus.In1);
          else            q0.push_back(bus.In1);
        end
        if (q0.size() > 0) last0 = q0[0];
        if (q1.size() > 0) last1 = q1[0];
      end
    end
  end

  // Per-cycle comparison against the model.
  initial begin
    forever begin
      @(negedge clk);
      check("out1_valid", 32'(bus.out1_valid), 32'(q0.size() != 0));
      check("out2_valid", 32'(bus.out2_valid), 32'(q1.size() != 0));
      check("out1", 32'(bus.out1), 32'((q0.size() != 0) ? q0[0] : last0));
      check("out2", 32'(bus.out2), 32'((q1.size() != 0) ? q1[0] : last1));
      check("in_ready", 32'(bus.in_ready),
            32'(!reset && ((bus.signal ? q1.size() : q0.size()) < 2)));
`ifdef DEMUX_COUNT_EN
      check("cnt1", 32'(bus.cnt1), 32'(pops0 % 256));
      check("cnt2", 32'(bus.cnt2), 32'(pops1 % 256));
`endif
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    // Held in reset
    check("rst_out1_valid", 32'(bus.out1_valid), 32'd0);
    check("rst_out1", 32'(bus.out1), 32'd0);
    check("rst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    reset = 1'b0;

    // Single push to channel 1
    drive(1'b1, 1'b0, 2'b10, 1'b0, 1'b0);
    tick();
    check("push_out1", 32'(bus.out1), 32'(2'b10));
    check("push_out1_valid", 32'(bus.out1_valid), 32'd1);
    check("push_out2_valid", 32'(bus.out2_valid), 32'd0);
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    check("drain_out1_valid", 32'(bus.out1_valid), 32'd0);
    check("hold_out1", 32'(bus.out1), 32'(2'b10));

    // Fill channel 2
    drive(1'b1, 1'b1, 2'b01, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 2'b11, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b1, 2'b00, 1'b0, 1'b0);
    #1;
    check("full_in_ready_sel2", 32'(bus.in_ready), 32'd0);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    #1;
    check("full_in_ready_sel1", 32'(bus.in_ready), 32'd1);
    check("full_head2", 32'(bus.out2), 32'(2'b01));
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b1);
    tick();
    check("pop2_second", 32'(bus.out2), 32'(2'b11));
    check("pop2_valid", 32'(bus.out2_valid), 32'd1);
    tick();
    check("pop2_empty", 32'(bus.out2_valid), 32'd0);

    // Independence: channel 2 full while channel 1 streams
    drive(1'b1, 1'b1, 2'b10, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 2'b00, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 4; i++) begin
      logic [1:0] w;
      w = 2'(i);
      drive(1'b1, 1'b0, w, 1'b1, 1'b0);
      tick();
      check("stream_out1", 32'(bus.out1), 32'(w));
      check("stream_in_ready", 32'(bus.in_ready), 32'd1);
      check("stream_out2_valid", 32'(bus.out2_valid), 32'd1);
    end

    // Simultaneous push and pop with one entry
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    check("one_pre_empty", 32'(bus.out1_valid), 32'd0);
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    tick();
    check("one_head", 32'(bus.out1), 32'(2'b01));
    drive(1'b1, 1'b0, 2'b10, 1'b1, 1'b0);
    tick();
    check("one_swap_out1", 32'(bus.out1), 32'(2'b10));
    check("one_swap_valid", 32'(bus.out1_valid), 32'd1);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    check("one_single_entry", 32'(bus.out1_valid), 32'd0);

    // Asynchronous reset with both channels full
    drive(1'b1, 1'b0, 2'b01, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    tick();
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);
    check("pre_rst_full1", 32'(bus.out1_valid & bus.out2_valid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("arst_out1_valid", 32'(bus.out1_valid), 32'd0);
    check("arst_out2_valid", 32'(bus.out2_valid), 32'd0);
    check("arst_out1", 32'(bus.out1), 32'd0);
    check("arst_out2", 32'(bus.out2), 32'd0);
    check("arst_in_ready", 32'(bus.in_ready), 32'd0);
    tick();
    reset = 1'b0;
    drive(1'b1, 1'b0, 2'b11, 1'b0, 1'b0);
    tick();
    check("post_rst_out1", 32'(bus.out1), 32'(2'b11));
    check("post_rst_valid", 32'(bus.out1_valid), 32'd1);
    drive(1'b0, 1'b0, 2'b00, 1'b0, 1'b0);

`ifdef DEMUX_COUNT_EN
    // Counter wrap: 257 deliveries on channel 1
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("cnt1_reset", 32'(bus.cnt1), 32'd0);
    for (int i = 0; i < 257; i++) begin
      logic [1:0] w;
      w = 2'(i);
      drive(1'b1, 1'b0, w, 1'b1, 1'b0);
      tick();
    end
    drive(1'b0, 1'b0, 2'b00, 1'b1, 1'b0);
    tick();
    check("cnt1_wrap", 32'(bus.cnt1), 32'd1);
    check("cnt2_idle", 32'(bus.cnt2), 32'd0);
`endif

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
